// File: rtl/serial_1101_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_1101_tx
//  Description : Serial frame transmitter. On an accepted start it sends the
//                header 1101, then a DATA_W-bit payload MSB first, then one
//                guard 0 bit. The line idles low. Back-to-back frames are
//                accepted during the guard cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_1101_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              x,
  output logic              ready,
  output logic              busy,
  output logic              done
);

  // Counter must reach 3 for the header and DATA_W-1 for the payload.
  localparam int MAX_W = (DATA_W > 4) ? DATA_W : 4;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);

  // The state names the phase whose bit is driven onto x at the next edge,
  // so x, busy and done all change together on the same edge.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GUARD   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              x_n, busy_n, done_n;
  logic              hdr_bit;
  logic              accept;

  // Ready depends only on registered state, never on start.
  assign ready  = (state == S_IDLE) || (state == S_GUARD);
  assign accept = start && ready;

  // Header bit selected by the counter: sequence 1,1,0,1.
  always_comb begin
    hdr_bit = 1'b1;
    if (cnt[1:0] == 2'd2) begin
      hdr_bit = 1'b0;
    end
  end

  // Next-state, next-line-value and datapath updates.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    x_n     = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (accept) begin
          shreg_n = data;
          cnt_n   = '0;
          state_n = S_HEADER;
        end
      end
      S_HEADER: begin
        x_n = hdr_bit;
        if (cnt == HDR_LAST) begin
          cnt_n   = '0;
          state_n = S_PAYLOAD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PAYLOAD: begin
        x_n     = shreg[DATA_W-1];
        shreg_n = shreg << 1;
        if (cnt == PAY_LAST) begin
          cnt_n   = '0;
          state_n = S_GUARD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GUARD: begin
        done_n = 1'b1;
        if (accept) begin
          shreg_n = data;
          cnt_n   = '0;
          state_n = S_HEADER;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      x     <= x_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_1101_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_1101_tx
//  Description : Self-checking bench for serial_1101_tx (DATA_W=8 and 1).
//                Reference model: a queue of per-cycle line values built
//                from whole frames at the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_1101_tx;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] data;
  logic       x, ready, busy, done;

  logic       reset1, start1;
  logic [0:0] data1;
  logic       x1, ready1, busy1, done1;

  int n_pass  = 0;
  int n_total = 0;

  serial_1101_tx #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .x(x), .ready(ready), .busy(busy), .done(done)
  );

  serial_1101_tx #(.DATA_W(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .data(data1),
    .x(x1), .ready(ready1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic x; logic b; logic d; } ent_t;
  ent_t q[$];
  logic m_x, m_busy, m_done, m_ready;

  function automatic void model_edge(input logic r, input logic s, input logic [7:0] d);
    ent_t e;
    logic acc;
    logic [3:0] hdr;
    hdr = 4'b1101;
    if (r) begin
      q.delete();
      m_x = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      acc = s && (q.size() <= 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        m_x = e.x; m_busy = e.b; m_done = e.d;
      end else begin
        m_x = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end
      if (acc) begin
        for (int i = 3; i >= 0; i--) q.push_back('{x: hdr[i], b: 1'b1, d: 1'b0});
        for (int i = 7; i >= 0; i--) q.push_back('{x: d[i], b: 1'b1, d: 1'b0});
        q.push_back('{x: 1'b0, b: 1'b1, d: 1'b1});
      end
    end
    m_ready = (q.size() <= 1);
  endfunction

  function automatic void chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endfunction

  // Apply inputs, clock one edge, then compare against the model.
  task automatic cyc(input logic r, input logic s, input logic [7:0] d);
    reset = r; start = s; data = d;
    @(posedge clk);
    model_edge(r, s, d);
    @(negedge clk);
    chk("x", x, m_x);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("ready", ready, m_ready);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, st;
    logic [7:0] d;
    logic       ex, eb, ed, er;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic [7:0] d,
                              input logic ex, input logic eb, input logic ed, input logic er);
    vec_t v;
    v.rst = rst; v.st = st; v.d = d; v.ex = ex; v.eb = eb; v.ed = ed; v.er = er;
    return v;
  endfunction

  logic [27:0] b2b_exp;
  logic [27:0] b2b_got;
  int          done_cnt;
  logic [5:0]  w1_exp;

  initial begin
    reset = 1'b1; start = 1'b0; data = 8'h00;
    reset1 = 1'b1; start1 = 1'b0; data1 = 1'b0;
    m_x = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;

    // Reset 2 edges, 10 idle cycles, single A5 frame with a start at payload bit 3.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 0)); // accept edge
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0)); // header
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0)); // payload 1010_0101
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 1, 0, 0)); // ignored start
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1)); // guard
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].d);
      chk("tbl_x", x, tbl[i].ex);
      chk("tbl_busy", busy, tbl[i].eb);
      chk("tbl_done", done, tbl[i].ed);
      chk("tbl_ready", ready, tbl[i].er);
    end

    // Back-to-back: 0F with start held, 3C presented at the guard edge.
    b2b_exp  = 28'b1101_0000_1111_0_1101_0011_1100_0_00;
    done_cnt = 0;
    cyc(0, 1, 8'h0F);
    for (int k = 0; k < 28; k++) begin
      if (k < 12)       cyc(0, 1, 8'h0F);
      else if (k == 12) cyc(0, 1, 8'h3C);
      else              cyc(0, 0, 8'h00);
      b2b_got[27-k] = x;
      if (done === 1'b1) done_cnt++;
    end
    for (int k = 0; k < 28; k++) chk("b2b_stream", b2b_got[27-k], b2b_exp[27-k]);
    n_total++;
    if (done_cnt == 2) n_pass++;
    else $display("FAIL b2b_done_count: got %0d expected 2", done_cnt);

    // Reset mid-frame during payload bit 2, then a fresh frame.
    cyc(0, 1, 8'hA5);
    for (int k = 0; k < 6; k++) cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk("midrst_x", x, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 8'h00);
      chk("midrst_nodone", done, 1'b0);
    end
    cyc(0, 1, 8'h3C);
    for (int k = 0; k < 16; k++) cyc(0, 0, 8'h00);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
          8'($urandom));
    end

    // DATA_W = 1 instance: 1,1,0,1,1,0 with done on the 6th cycle.
    w1_exp = 6'b110110;
    @(posedge clk);
    @(negedge clk);
    chk("w1_rst_x", x1, 1'b0);
    chk("w1_rst_ready", ready1, 1'b1);
    reset1 = 1'b0; start1 = 1'b1; data1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; data1 = 1'b0;
    chk("w1_accept_busy", busy1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w1_x", x1, w1_exp[5-i]);
      chk("w1_done", done1, (i == 5) ? 1'b1 : 1'b0);
      chk("w1_busy", busy1, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("w1_idle_busy", busy1, 1'b0);
    chk("w1_idle_ready", ready1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_1101_tx.md
# serial_1101_tx

Serial frame transmitter that drives the single-bit line consumed by the 1101 sequence detector. On a start request it emits a fixed 4-bit header `1101`, then a DATA_W-bit payload MSB first, then one guard `0` bit. The line is low when the block is idle. The block sits on the sending side of the serial link, and its output `x` connects directly to the detector's `x` input on the same `clk`.

## Interface
- `DATA_W`, default 8: payload width in bits. Legal range is 1..32.
- `clk`  input  1: single clock; all logic is on the rising edge.
- `reset`  input  1: synchronous, active-high reset. It is sampled on the rising edge of `clk`.
- `start`  input  1: frame request. It is accepted only on an edge where `start && ready`.
- `data`  input  DATA_W: payload. It is captured on the accept edge.
- `x`  output  1: registered serial line output.
- `ready`  output  1: high when a start request will be accepted on this edge. This is true in IDLE or GUARD.
- `busy`  output  1: high from the first header bit through the guard bit.
- `done`  output  1: one-cycle pulse, high during the guard-bit cycle.

## Operation
- Registers:
  - 2-bit state.
  - DATA_W-bit shift register.
  - Bit counter, sized to hold max(4, DATA_W) - 1.
  - Registered `x`.
- Valid state encodings are IDLE, HEADER, PAYLOAD and GUARD. Any other encoding returns to IDLE on the next edge.
- IDLE: `x`=0, `busy`=0, `ready`=1.
  - On accept: load the shift register with `data`, set the counter to 0, and go to HEADER.
- HEADER: drive header bit `counter` of the sequence 1,1,0,1.
  - After the 4th bit, go to PAYLOAD with the counter cleared.
- PAYLOAD: drive the shift register MSB, then shift left by 1 with zero fill.
  - After DATA_W bits, go to GUARD.
- GUARD: `x`=0, `done`=1, `ready`=1.
  - On accept: reload from `data` and go to HEADER, giving back-to-back frames with one guard bit between them.
  - Otherwise go to IDLE.
- `start` while in HEADER or PAYLOAD is ignored. It is neither queued nor able to corrupt the frame in progress.
- `data` is sampled only on the accept edge. Later changes to `data` have no effect on the frame in progress.
- The payload is not escaped. A payload containing `1101`, or a header overlapping with the end of a payload, makes a downstream detector fire more than once per frame. This is required behaviour, and frame-level qualification is the receiver's concern.
- Reset takes priority over everything, including `start`.
  - On the reset edge: state is IDLE, `x`=0, `busy`=0, `done`=0, `ready`=1, and the shift register and counter are cleared.
  - A reset mid-frame aborts the frame, with no guard bit and no `done`.

## Timing
- Accept at edge T: `x` shows header bit 1 after edge T+1.
  - Header occupies T+1..T+4.
  - Payload occupies T+5..T+4+DATA_W.
  - Guard is at T+5+DATA_W.
  - Each bit holds for exactly one `clk` period.
- Frame length is DATA_W+5 cycles. Back-to-back throughput is one frame per DATA_W+5 cycles.
- `busy`, `done` and `ready` are registered, or decoded from registered state only. `ready` must not combinationally depend on `start`.
- `done` is high in exactly one cycle per completed frame, coincident with the guard bit.
- The connected detector's `y` pulses (Mealy) during the cycle in which the 4th header bit, `1`, is on `x`, i.e. after edge T+4.

## Test plan
- Reset and idle: hold `reset`=1 for 2 edges, then release with `start`=0 for 10 cycles. Required: `x`=0, `busy`=0, `done`=0 and `ready`=1 throughout.
- Single frame: DATA_W=8, `data`=8'hA5, 1-cycle `start`. Required:
  - `x` = 1,1,0,1, 1,0,1,0,0,1,0,1, 0, then idle 0.
  - `done` is high only in cycle 13 after accept.
  - The detector `y` pulses exactly once, at header bit 4.
- Start while busy: pulse `start` with `data`=8'hFF at payload bit 3. Required: the frame is unchanged (still 8'hA5) and the block returns to IDLE after the guard bit.
- Back-to-back: hold `start`=1 with `data`=8'h0F, then 8'h3C presented at the guard edge. Required:
  - Frame 2's header starts the cycle after the guard bit, with no idle gap.
  - Stream is 1101 00001111 0 1101 00111100 0.
  - `done` pulses twice.
- Reset mid-frame: assert `reset` for 1 edge during payload bit 2. Required: `x`=0 and `busy`=0 on the next cycle, no `done`, and a fresh `start` afterwards produces a complete, correct frame.
- Width edge: DATA_W=1 with `data`=1'b1. Required: `x` = 1,1,0,1,1,0, and `done` in cycle 6.
